npu_hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller between the ID-stage decoder and the NPU.

---
 rtl/npu_hazard_ctrl_pkg.sv | 25 ++
 rtl/npu_hazard_ctrl_if.sv | 31 +++
 rtl/npu_timeout_cnt.sv | 30 +++
 rtl/npu_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_npu_hazard_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/npu_hazard_ctrl_pkg.sv
// rtl/npu_hazard_ctrl_pkg.sv - shared state encoding and opcodes for the hazard controller
package npu_hazard_ctrl_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_BUSY = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_BUSY = ST_BUSY,
    S_WB   = ST_WB,
    S_ERR  = ST_ERR
  } state_e;

  localparam logic [6:0] NPU_OPCODE = 7'b0001011;
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LW     = 7'b0000011;
  localparam logic [6:0] OPC_SW     = 7'b0100011;
  localparam logic [6:0] OPC_SB     = 7'b1100011;

endpackage

// File: rtl/npu_hazard_ctrl_if.sv
// rtl/npu_hazard_ctrl_if.sv - ID-stage, NPU handshake and pipeline-control signal bundle
interface npu_hazard_ctrl_if;

  logic [6:0] id_opcode;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       branch_taken;
  logic       npu_ack;
  logic       npu_done;
  logic       npu_req;
  logic       npu_stall;
  logic       ctrl_src;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       npu_wb;
  logic       npu_err;

  modport master (
    output id_opcode, id_rs1, id_rs2, ex_rd, ex_mem_read, branch_taken, npu_ack, npu_done,
    input  npu_req, npu_stall, ctrl_src, pc_write, if_id_write, if_id_flush, npu_wb, npu_err
  );

  modport slave (
    input  id_opcode, id_rs1, id_rs2, ex_rd, ex_mem_read, branch_taken, npu_ack, npu_done,
    output npu_req, npu_stall, ctrl_src, pc_write, if_id_write, if_id_flush, npu_wb, npu_err
  );

endinterface

// File: rtl/npu_timeout_cnt.sv
// rtl/npu_timeout_cnt.sv - cycle counter bounding an NPU offload
module npu_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expiry flags the last allowed cycle so the FSM can leave on the next edge.
  assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/npu_hazard_ctrl.sv
// rtl/npu_hazard_ctrl.sv - load-use bubbles, branch flush and NPU offload sequencing
import npu_hazard_ctrl_pkg::*;

module npu_hazard_ctrl #(
  parameter logic [6:0] P_NPU_OPCODE = NPU_OPCODE,
  parameter int         TIMEOUT_CYC  = 1024
) (
  input  logic              CLK,
  input  logic              RSTn,
  npu_hazard_ctrl_if.slave  hz
);

  state_e r_state;
  state_e w_next;
  logic   r_npu_req;
  logic   w_lu;
  logic   w_stall;
  logic   w_ctrl_src;
  logic   w_pc_write;
  logic   w_if_id_write;
  logic   w_flush;
  logic   w_wb;
  logic   w_err;
  logic   w_cnt_clr;
  logic   w_cnt_en;
  logic   w_expire;

  assign w_lu = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));

  npu_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state   <= S_IDLE;
      r_npu_req <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_npu_req <= (w_next == S_REQ);
    end
  end

  // Outputs are forced to their idle values while reset is asserted, whatever the inputs.
  always_comb begin
    w_next        = r_state;
    w_stall       = 1'b0;
    w_ctrl_src    = 1'b0;
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_flush       = 1'b0;
    w_wb          = 1'b0;
    w_err         = 1'b0;
    w_cnt_clr     = 1'b0;
    w_cnt_en      = 1'b0;
    if (RSTn) begin
      case (r_state)
        S_IDLE: begin
          if (hz.branch_taken) begin
            w_flush    = 1'b1;
            w_ctrl_src = 1'b1;
          end else if (w_lu) begin
            w_ctrl_src    = 1'b1;
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
          end else if (hz.id_opcode == P_NPU_OPCODE) begin
            w_stall       = 1'b1;
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_cnt_clr     = 1'b1;
            w_next        = S_REQ;
          end
        end
        S_REQ: begin
          w_stall       = 1'b1;
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_cnt_en      = 1'b1;
          if (hz.npu_ack && hz.npu_done) begin
            w_next = S_WB;
          end else if (w_expire) begin
            w_next = S_ERR;
          end else if (hz.npu_ack) begin
            w_next = S_BUSY;
          end
        end
        S_BUSY: begin
          w_stall       = 1'b1;
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_cnt_en      = 1'b1;
          if (hz.npu_done) begin
            w_next = S_WB;
          end else if (w_expire) begin
            w_next = S_ERR;
          end
        end
        S_WB: begin
          w_wb   = 1'b1;
          w_next = S_IDLE;
        end
        S_ERR: begin
          w_err      = 1'b1;
          w_ctrl_src = 1'b1;
          w_next     = S_IDLE;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  assign hz.npu_req     = r_npu_req;
  assign hz.npu_stall   = w_stall;
  assign hz.ctrl_src    = w_ctrl_src;
  assign hz.pc_write    = w_pc_write;
  assign hz.if_id_write = w_if_id_write;
  assign hz.if_id_flush = w_flush;
  assign hz.npu_wb      = w_wb;
  assign hz.npu_err     = w_err;

endmodule

// File: tb/tb_npu_hazard_ctrl.sv
// tb/tb_npu_hazard_ctrl.sv - scoreboard bench for npu_hazard_ctrl
import npu_hazard_ctrl_pkg::*;

module tb_npu_hazard_ctrl;

  // Output vector order: {req, stall, ctrl_src, pc_write, if_id_write, flush, wb, err}
  localparam logic [7:0] E_IDLE  = 8'h18;
  localparam logic [7:0] E_BUB   = 8'h20;
  localparam logic [7:0] E_FLUSH = 8'h3C;
  localparam logic [7:0] E_START = 8'h40;
  localparam logic [7:0] E_REQ   = 8'hC0;
  localparam logic [7:0] E_BUSY  = 8'h40;
  localparam logic [7:0] E_WB    = 8'h1A;
  localparam logic [7:0] E_ERR   = 8'h39;

  logic CLK;
  logic RSTn;
  int   n_chk;
  int   n_pass;
  string      tag_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] w_obs;

  npu_hazard_ctrl_if hz();

  npu_hazard_ctrl #(
    .P_NPU_OPCODE (NPU_OPCODE),
    .TIMEOUT_CYC  (8)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .hz   (hz)
  );

  assign w_obs = {hz.npu_req, hz.npu_stall, hz.ctrl_src, hz.pc_write,
                  hz.if_id_write, hz.if_id_flush, hz.npu_wb, hz.npu_err};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %b expected %b (req stall ctrl pcw ifw flush wb err)", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step(input string tag, input logic [6:0] opc, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd, input logic mr,
                      input logic br, input logic ack, input logic done, input logic [7:0] exp);
    @(posedge CLK);
    #1;
    hz.id_opcode    = opc;
    hz.id_rs1       = rs1;
    hz.id_rs2       = rs2;
    hz.ex_rd        = rd;
    hz.ex_mem_read  = mr;
    hz.branch_taken = br;
    hz.npu_ack      = ack;
    hz.npu_done     = done;
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  // While the NPU runs the ID side shows a hostile branch plus load-use; both must be ignored.
  task automatic hold(input string tag, input logic ack, input logic done, input logic [7:0] exp);
    step(tag, NPU_OPCODE, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1, ack, done, exp);
  endtask

  task automatic nop(input string tag);
    step(tag, OPC_I, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
  endtask

  task automatic npu_start(input string tag);
    step(tag, NPU_OPCODE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, E_START);
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      string      t;
      logic [7:0] e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      chk(t, w_obs, e);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    RSTn            = 1'b0;
    hz.id_opcode    = NPU_OPCODE;
    hz.id_rs1       = 5'd4;
    hz.id_rs2       = 5'd4;
    hz.ex_rd        = 5'd4;
    hz.ex_mem_read  = 1'b1;
    hz.branch_taken = 1'b1;
    hz.npu_ack      = 1'b0;
    hz.npu_done     = 1'b0;
    #7;
    chk("reset", w_obs, E_IDLE);
    #15;
    RSTn = 1'b1;

    // load-use: one bubble, then the pipeline moves on with a bubble in EX
    step("lu_rs1", OPC_R, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_BUB);
    step("lu_adv", OPC_R, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
    step("lu_rd0", OPC_R, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE);
    step("lu_rs2", OPC_SW, 5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, E_BUB);
    step("no_load", OPC_R, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);

    // branch beats NPU start
    step("br_npu", NPU_OPCODE, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, E_FLUSH);
    nop("br_after");

    // ack at +2, done at +5; done without ack in REQ is ignored
    npu_start("n_start");
    hold("n_req1", 1'b0, 1'b1, E_REQ);
    hold("n_req2", 1'b1, 1'b0, E_REQ);
    hold("n_busy1", 1'b0, 1'b0, E_BUSY);
    hold("n_busy2", 1'b0, 1'b0, E_BUSY);
    hold("n_done", 1'b0, 1'b1, E_BUSY);
    hold("n_wb", 1'b0, 1'b0, E_WB);
    nop("n_idle");

    // load-use on an NPU op defers start by one cycle; ack+done together gives minimum latency
    step("nl_bub", NPU_OPCODE, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, E_BUB);
    step("nl_go", NPU_OPCODE, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_START);
    hold("nl_req", 1'b1, 1'b1, E_REQ);
    hold("nl_wb", 1'b0, 1'b0, E_WB);
    nop("nl_idle");

    // timeout after 8 cycles in REQ+BUSY
    npu_start("to_start");
    hold("to_req", 1'b1, 1'b0, E_REQ);
    for (int i = 0; i < 7; i++) hold("to_busy", 1'b0, 1'b0, E_BUSY);
    hold("to_err", 1'b0, 1'b0, E_ERR);
    nop("to_idle");

    // done on the 8th cycle wins over the timeout
    npu_start("tw_start");
    hold("tw_req", 1'b1, 1'b0, E_REQ);
    for (int i = 0; i < 6; i++) hold("tw_busy", 1'b0, 1'b0, E_BUSY);
    hold("tw_done8", 1'b0, 1'b1, E_BUSY);
    hold("tw_wb", 1'b0, 1'b0, E_WB);
    nop("tw_idle");

    // never acked: timeout straight out of REQ
    npu_start("tr_start");
    for (int i = 0; i < 8; i++) hold("tr_req", 1'b0, 1'b0, E_REQ);
    hold("tr_err", 1'b0, 1'b0, E_ERR);
    nop("tr_idle");

    // async reset while BUSY
    npu_start("ar_start");
    hold("ar_req", 1'b1, 1'b0, E_REQ);
    hold("ar_busy", 1'b0, 1'b0, E_BUSY);
    @(posedge CLK);
    #3;
    RSTn = 1'b0;
    #1;
    chk("ar_async", w_obs, E_IDLE);
    @(negedge CLK);
    chk("ar_hold", w_obs, E_IDLE);
    #2;
    RSTn = 1'b1;
    nop("ar_idle");
    npu_start("ar_restart");
    hold("ar_req2", 1'b1, 1'b1, E_REQ);
    hold("ar_wb", 1'b0, 1'b0, E_WB);
    nop("ar_end");

    @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expected results left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
